// File: rtl/banked_way_array_pkg.sv
// Shared types and helpers for banked_way_array: flush FSM states,
// per-byte masked merge, and per-byte even parity.
package banked_way_array_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } flush_state_t;

  // One byte lane of a masked write: take new_b where mask is set.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       mask);
    return mask ? new_b : old_b;
  endfunction

  // Even-parity bit for one byte lane; fold lanes with XOR for a word.
  function automatic logic even_parity(input logic [7:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/banked_way_array_if.sv
// Bus interface for banked_way_array.
// Optional macro BANKED_WAY_ARRAY_PARITY_EN adds the parity_err output.
interface banked_way_array_if #(
  parameter int S_INDEX = 3,
  parameter int WIDTH   = 32,
  parameter int WAYS    = 2
);
  logic                  read;
  logic [S_INDEX-1:0]    rindex;
  logic [WAYS-1:0]       load;
  logic [S_INDEX-1:0]    windex;
  logic [WIDTH/8-1:0]    wmask;
  logic [WIDTH-1:0]      datain;
  logic [WAYS*WIDTH-1:0] dataout;
  logic                  flush;
  logic                  busy;
  logic                  flush_done;
`ifdef BANKED_WAY_ARRAY_PARITY_EN
  logic [WAYS-1:0]       parity_err;
`endif

  modport master (
    output read, rindex, load, windex, wmask, datain, flush,
    input  dataout, busy, flush_done
`ifdef BANKED_WAY_ARRAY_PARITY_EN
    , input parity_err
`endif
  );

  modport slave (
    input  read, rindex, load, windex, wmask, datain, flush,
    output dataout, busy, flush_done
`ifdef BANKED_WAY_ARRAY_PARITY_EN
    , output parity_err
`endif
  );
endinterface

// File: rtl/banked_way_array_way_bank.sv
// Single-way NUM_SETS x WIDTH storage: masked write, clear-by-index, reset.
// Combinational read at i_rindex and merged (post-write) value at i_windex.
// Optional macro BANKED_WAY_ARRAY_PARITY_EN adds a stored parity bit per entry.
module way_bank
  import banked_way_array_pkg::*;
#(
  parameter int S_INDEX = 3,
  parameter int WIDTH   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_we,
  input  logic [S_INDEX-1:0] i_windex,
  input  logic [WIDTH/8-1:0] i_wmask,
  input  logic [WIDTH-1:0]   i_wdata,
  input  logic               i_clr,
  input  logic [S_INDEX-1:0] i_cindex,
  input  logic [S_INDEX-1:0] i_rindex,
  output logic [WIDTH-1:0]   o_rdata,
  output logic [WIDTH-1:0]   o_wmerged
`ifdef BANKED_WAY_ARRAY_PARITY_EN
  , output logic             o_rpar,
  output logic               o_rpar_calc,
  output logic               o_wpar
`endif
);
  localparam int NUM_SETS = 2 ** S_INDEX;
  localparam int NBYTES   = WIDTH / 8;

  logic [WIDTH-1:0] r_mem [NUM_SETS];
  logic [WIDTH-1:0] w_old;

  assign w_old   = r_mem[i_windex];
  assign o_rdata = r_mem[i_rindex];

  // Byte-lane merge of write data over the currently stored word.
  always_comb begin
    o_wmerged = '0;
    for (int unsigned b = 0; b < NBYTES; b++)
      o_wmerged[b*8 +: 8] = byte_merge(w_old[b*8 +: 8], i_wdata[b*8 +: 8], i_wmask[b]);
  end

  // Storage update: reset and clear win over a write (never concurrent in practice).
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) r_mem[s] <= '0;
    end else if (i_clr) begin
      r_mem[i_cindex] <= '0;
    end else if (i_we) begin
      r_mem[i_windex] <= o_wmerged;
    end
  end

`ifdef BANKED_WAY_ARRAY_PARITY_EN
  logic r_par [NUM_SETS];

  assign o_rpar = r_par[i_rindex];

  // Parity of the merged write word and of the word currently read.
  always_comb begin
    o_wpar      = 1'b0;
    o_rpar_calc = 1'b0;
    for (int unsigned b = 0; b < NBYTES; b++) begin
      o_wpar      = o_wpar ^ even_parity(o_wmerged[b*8 +: 8]);
      o_rpar_calc = o_rpar_calc ^ even_parity(o_rdata[b*8 +: 8]);
    end
  end

  // Parity storage tracks the data storage update rules.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) r_par[s] <= 1'b0;
    end else if (i_clr) begin
      r_par[i_cindex] <= 1'b0;
    end else if (i_we) begin
      r_par[i_windex] <= o_wpar;
    end
  end
`endif

endmodule

// File: rtl/banked_way_array.sv
// Multi-way set-associative storage array: WAYS banks, registered read with
// hold, write-to-read forwarding and a sequenced flush engine.
// Optional macro BANKED_WAY_ARRAY_PARITY_EN enables per-entry parity checking.
module banked_way_array
  import banked_way_array_pkg::*;
#(
  parameter int S_INDEX = 3,
  parameter int WIDTH   = 32,
  parameter int WAYS    = 2
) (
  input logic               clk,
  input logic               rst,
  banked_way_array_if.slave bus
);
  flush_state_t          r_state;
  logic [S_INDEX-1:0]    r_cnt;
  logic                  r_busy;
  logic                  r_flush_done;
  logic [WAYS*WIDTH-1:0] r_dataout;

  logic                  w_idle;
  logic                  w_clr;
  logic                  w_same_idx;
  logic [WIDTH-1:0]      w_rdata   [WAYS];
  logic [WIDTH-1:0]      w_wmerged [WAYS];

  assign w_idle     = (r_state == IDLE);
  assign w_clr      = (r_state == CLEAR);
  assign w_same_idx = (bus.rindex == bus.windex);

`ifdef BANKED_WAY_ARRAY_PARITY_EN
  logic [WAYS-1:0] r_parity_err;
  logic            w_rpar      [WAYS];
  logic            w_rpar_calc [WAYS];
  logic            w_wpar      [WAYS];
`endif

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    way_bank #(.S_INDEX(S_INDEX), .WIDTH(WIDTH)) u_bank (
      .clk        (clk),
      .rst        (rst),
      .i_we       (bus.load[w] & w_idle),
      .i_windex   (bus.windex),
      .i_wmask    (bus.wmask),
      .i_wdata    (bus.datain),
      .i_clr      (w_clr),
      .i_cindex   (r_cnt),
      .i_rindex   (bus.rindex),
      .o_rdata    (w_rdata[w]),
      .o_wmerged  (w_wmerged[w])
`ifdef BANKED_WAY_ARRAY_PARITY_EN
      , .o_rpar   (w_rpar[w]),
      .o_rpar_calc(w_rpar_calc[w]),
      .o_wpar     (w_wpar[w])
`endif
    );
  end

  // Flush sequencer with registered busy / flush_done.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_flush_done <= 1'b0;
          if (bus.flush) begin
            r_state <= CLEAR;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == '1) begin
            r_state      <= DONE;
            r_flush_done <= 1'b1;
          end
        end
        DONE: begin
          r_state      <= IDLE;
          r_busy       <= 1'b0;
          r_flush_done <= 1'b0;
        end
        default: begin
          r_state      <= IDLE;
          r_busy       <= 1'b0;
          r_flush_done <= 1'b0;
        end
      endcase
    end
  end

  // Read output register: hold when idle-read is off, zero while busy, forward same-set writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dataout <= '0;
    end else if (bus.read) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (r_busy)
          r_dataout[w*WIDTH +: WIDTH] <= '0;
        else if (bus.load[w] && w_same_idx)
          r_dataout[w*WIDTH +: WIDTH] <= w_wmerged[w];
        else
          r_dataout[w*WIDTH +: WIDTH] <= w_rdata[w];
      end
    end
  end

`ifdef BANKED_WAY_ARRAY_PARITY_EN
  // Parity error flags: forwarded words carry fresh parity so never flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_parity_err <= '0;
    end else begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (!bus.read || r_busy || (bus.load[w] && w_same_idx))
          r_parity_err[w] <= 1'b0;
        else
          r_parity_err[w] <= w_rpar_calc[w] ^ w_rpar[w];
      end
    end
  end

  assign bus.parity_err = r_parity_err;
`endif

  assign bus.dataout    = r_dataout;
  assign bus.busy       = r_busy;
  assign bus.flush_done = r_flush_done;

endmodule
